multichannel_asic_interface: RTL and testbench

MULTICHANNEL_ASIC_INTERFACE -- requirements
Module: multichannel_asic_interface

---
 rtl/multichannel_asic_interface.sv | 237 +++++++++++++++++++++++
 tb/tb_multichannel_asic_interface.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_asic_interface.sv
// -----------------------------------------------------------------------------
// multichannel_asic_interface
//
// Sequences one DAC-write / settle / ADC-sample transaction per start pulse:
//   IDLE -> SHIFT -> LDAC -> SETTLE -> SAMPLE -> DONE -> IDLE
// SHIFT sends an (8+DATA_WIDTH)-bit SPI frame MSB first:
//   {4'b0011 (write+update), 4-bit channel address, data_in}.
// LDAC pulses dac_ldac_n low for SCLK_DIV cycles. SETTLE waits SETTLE_CYCLES.
// SAMPLE holds adc_req until adc_ack, or for at most ADC_TIMEOUT cycles.
// DONE strobes data_valid for one cycle.
//
// Timing detail: LDAC begins with one idle cycle between dac_cs_n rising and
// dac_ldac_n falling. With adc_ack on the first SAMPLE cycle, data_valid is
// high in the cycle after edge
//   2*SCLK_DIV*(8+DATA_WIDTH) + 1 + SCLK_DIV + SETTLE_CYCLES + 1
// when the edge that accepts start is counted as edge 0. That is one edge
// earlier than 1 + 2*SCLK_DIV*(8+DATA_WIDTH) + 1 + SCLK_DIV + SETTLE_CYCLES + 1.
//
// Ports
//   clk, rst (sync, active low)   system clock / reset
//   start, ch_sel, data_in        transaction request (accepted in IDLE only)
//   busy                          transaction in progress
//   data_valid, data_out, ch_out  one-cycle result strobe, result, channel
//   timeout_err                   result invalid because the ADC never acked
//   dac_cs_n, dac_ldac_n,
//   dac_sclk, dac_din             SPI DAC pins
//   adc_req, adc_ch               sample request and channel to the ADC
//   adc_ack, adc_data             sample ready and value from the ADC
// -----------------------------------------------------------------------------
module multichannel_asic_interface #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADC_WIDTH     = 16,
  parameter int NUM_CH        = 4,
  parameter int SCLK_DIV      = 2,
  parameter int SETTLE_CYCLES = 64,
  parameter int ADC_TIMEOUT   = 1024,
  localparam int CH_BITS      = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CH_BITS-1:0]    ch_sel,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  data_valid,
  output logic [ADC_WIDTH-1:0]  data_out,
  output logic [CH_BITS-1:0]    ch_out,
  output logic                  timeout_err,
  output logic                  dac_cs_n,
  output logic                  dac_ldac_n,
  output logic                  dac_sclk,
  output logic                  dac_din,
  output logic                  adc_req,
  output logic [CH_BITS-1:0]    adc_ch,
  input  logic                  adc_ack,
  input  logic [ADC_WIDTH-1:0]  adc_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_LDAC, S_SETTLE, S_SAMPLE, S_DONE
  } state_t;

  localparam int FRAME_W = 8 + DATA_WIDTH;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int CNT_MAX = (ADC_TIMEOUT > SETTLE_CYCLES)
                         ? ((ADC_TIMEOUT > SCLK_DIV) ? ADC_TIMEOUT : SCLK_DIV)
                         : ((SETTLE_CYCLES > SCLK_DIV) ? SETTLE_CYCLES : SCLK_DIV);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] LDAC_LAST    = CNT_W'(SCLK_DIV);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ADC_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_next;
  logic [CH_BITS-1:0]   r_ch;
  logic [FRAME_W-1:0]   r_shift;
  logic [DIV_W-1:0]     r_div;
  logic [BIT_W-1:0]     r_bit;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_data_valid;
  logic [ADC_WIDTH-1:0] r_data_out;
  logic [CH_BITS-1:0]   r_ch_out;
  logic                 r_timeout_err;
  logic                 r_cs_n;
  logic                 r_ldac_n;
  logic                 r_sclk;
  logic                 r_adc_req;

  logic [3:0]           w_addr;
  logic [FRAME_W-1:0]   w_frame;
  logic                 w_sclk_tick;
  logic                 w_last_fall;
  logic                 w_ldac_done;
  logic                 w_settle_done;
  logic                 w_timeout;

  assign w_addr        = 4'(ch_sel);
  assign w_frame       = {4'b0011, w_addr, data_in};
  assign w_sclk_tick   = (r_div == DIV_LAST);
  assign w_last_fall   = w_sclk_tick && r_sclk && (r_bit == BIT_LAST);
  assign w_ldac_done   = (r_cnt == LDAC_LAST);
  assign w_settle_done = (r_cnt == SETTLE_LAST);
  assign w_timeout     = (r_cnt == TIMEOUT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through the case leaves w_next
    // unassigned and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start)                w_next = S_SHIFT;
      S_SHIFT:  if (w_last_fall)          w_next = S_LDAC;
      S_LDAC:   if (w_ldac_done)          w_next = S_SETTLE;
      S_SETTLE: if (w_settle_done)        w_next = S_SAMPLE;
      S_SAMPLE: if (adc_ack || w_timeout) w_next = S_DONE;
      S_DONE:                             w_next = S_IDLE;
      default:                            w_next = S_IDLE;
    endcase
  end

  // Datapath and registered pin drivers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ch          <= '0;
      r_shift       <= '0;
      r_div         <= '0;
      r_bit         <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_data_valid  <= 1'b0;
      r_data_out    <= '0;
      r_ch_out      <= '0;
      r_timeout_err <= 1'b0;
      r_cs_n        <= 1'b1;
      r_ldac_n      <= 1'b1;
      r_sclk        <= 1'b0;
      r_adc_req     <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ch    <= ch_sel;
            r_shift <= w_frame;
            r_busy  <= 1'b1;
            r_cs_n  <= 1'b0;
            r_sclk  <= 1'b0;
            r_div   <= '0;
            r_bit   <= '0;
          end
        end
        S_SHIFT: begin
          if (w_sclk_tick) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            // Falling edge: present the next bit. Zero fill leaves dac_din=0
            // once the last bit has gone.
            if (r_sclk) begin
              r_shift <= r_shift << 1;
              r_bit   <= r_bit + 1'b1;
              if (w_last_fall) begin
                r_cs_n <= 1'b1;
                r_cnt  <= '0;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_LDAC: begin
          // Count 0 is the CS-to-LDAC gap; ldac_n is low for counts 1..SCLK_DIV.
          if (r_cnt == '0) r_ldac_n <= 1'b0;
          if (w_ldac_done) begin
            r_ldac_n <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (w_settle_done) begin
            r_cnt     <= '0;
            r_adc_req <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          // An ack on the expiry cycle takes priority over the timeout.
          if (adc_ack) begin
            r_data_out    <= adc_data;
            r_timeout_err <= 1'b0;
            r_adc_req     <= 1'b0;
            r_data_valid  <= 1'b1;
            r_ch_out      <= r_ch;
          end else if (w_timeout) begin
            r_data_out    <= '1;
            r_timeout_err <= 1'b1;
            r_adc_req     <= 1'b0;
            r_data_valid  <= 1'b1;
            r_ch_out      <= r_ch;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign data_valid  = r_data_valid;
  assign data_out    = r_data_out;
  assign ch_out      = r_ch_out;
  assign timeout_err = r_timeout_err;
  assign dac_cs_n    = r_cs_n;
  assign dac_ldac_n  = r_ldac_n;
  assign dac_sclk    = r_sclk;
  assign dac_din     = r_shift[FRAME_W-1];
  assign adc_req     = r_adc_req;
  assign adc_ch      = r_ch;

endmodule

// File: tb/tb_multichannel_asic_interface.sv
// -----------------------------------------------------------------------------
// tb_multichannel_asic_interface
//
// Instance A uses default parameters. Instance B uses SCLK_DIV=1,
// DATA_WIDTH=12, NUM_CH=8 and short settle/timeout values. Expected SPI frames
// and results are queued when a transaction is launched. Negedge monitors
// decode the SPI pins and data_valid strobes and compare them against the
// queue heads.
// -----------------------------------------------------------------------------
module tb_multichannel_asic_interface;

  localparam int A_D = 2, A_N = 24, A_S = 64, A_T = 1024;
  localparam int B_D = 1, B_N = 20, B_S = 8,  B_T = 16;
  // Cycle formula from start to data_valid, ack on the first SAMPLE cycle.
  localparam int A_F = 1 + 2*A_D*A_N + 1 + A_D + A_S + 1;
  localparam int B_F = 1 + 2*B_D*B_N + 1 + B_D + B_S + 1;

  typedef struct {
    logic [3:0]  ch;
    logic [15:0] data;
    int          ack_delay;   // -1: the ADC never acks
    logic [15:0] adc_val;
    logic [31:0] exp_frame;
    logic [15:0] exp_out;
    logic        exp_terr;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  ch;
    logic        terr;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A signals
  logic        start_a, busy_a, dv_a, terr_a, cs_a, ldac_a, sclk_a, din_a, req_a, ack_a;
  logic [1:0]  ch_sel_a, chout_a, adc_ch_a;
  logic [15:0] data_a, dout_a, adc_data_a;
  // Instance B signals
  logic        start_b, busy_b, dv_b, terr_b, cs_b, ldac_b, sclk_b, din_b, req_b, ack_b;
  logic [2:0]  ch_sel_b, chout_b, adc_ch_b;
  logic [11:0] data_b;
  logic [15:0] dout_b, adc_data_b;

  multichannel_asic_interface u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ch_sel(ch_sel_a), .data_in(data_a),
    .busy(busy_a), .data_valid(dv_a), .data_out(dout_a), .ch_out(chout_a),
    .timeout_err(terr_a), .dac_cs_n(cs_a), .dac_ldac_n(ldac_a), .dac_sclk(sclk_a),
    .dac_din(din_a), .adc_req(req_a), .adc_ch(adc_ch_a), .adc_ack(ack_a),
    .adc_data(adc_data_a)
  );

  multichannel_asic_interface #(
    .DATA_WIDTH(12), .ADC_WIDTH(16), .NUM_CH(8), .SCLK_DIV(B_D),
    .SETTLE_CYCLES(B_S), .ADC_TIMEOUT(B_T)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ch_sel(ch_sel_b), .data_in(data_b),
    .busy(busy_b), .data_valid(dv_b), .data_out(dout_b), .ch_out(chout_b),
    .timeout_err(terr_b), .dac_cs_n(cs_b), .dac_ldac_n(ldac_b), .dac_sclk(sclk_b),
    .dac_din(din_b), .adc_req(req_b), .adc_ch(adc_ch_b), .adc_ack(ack_b),
    .adc_data(adc_data_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues
  logic [31:0] fr_qa[$], fr_qb[$];
  res_t        res_qa[$], res_qb[$];

  // ADC behavioural models: ack 'delay' cycles after adc_req is first seen.
  int          delay_a = 0, delay_b = 0, acnt_a = 0, acnt_b = 0;
  logic [15:0] val_a = '0, val_b = '0;

  initial begin
    ack_a = 1'b0; adc_data_a = '0;
    forever begin
      @(negedge clk);
      if (ack_a) begin
        ack_a = 1'b0; acnt_a = 0;
      end else if (req_a && delay_a >= 0) begin
        if (acnt_a == delay_a) begin ack_a = 1'b1; adc_data_a = val_a; end
        else acnt_a++;
      end else acnt_a = 0;
    end
  end

  initial begin
    ack_b = 1'b0; adc_data_b = '0;
    forever begin
      @(negedge clk);
      if (ack_b) begin
        ack_b = 1'b0; acnt_b = 0;
      end else if (req_b && delay_b >= 0) begin
        if (acnt_b == delay_b) begin ack_b = 1'b1; adc_data_b = val_b; end
        else acnt_b++;
      end else acnt_b = 0;
    end
  end

  // SPI / LDAC monitor state, per instance
  logic [31:0] mon_sh[2];
  int          mon_rises[2], mon_ldac_cnt[2];
  logic        mon_psclk[2], mon_pcs[2], mon_pldac[2];

  task automatic spi_mon(input int u, input logic cs, input logic sc, input logic dn, input logic ld);
    logic [31:0] e;
    if (!rst) begin
      mon_sh[u] = '0; mon_rises[u] = 0; mon_ldac_cnt[u] = 0;
      mon_psclk[u] = 1'b0; mon_pcs[u] = 1'b1; mon_pldac[u] = 1'b1;
      return;
    end
    if (!cs && sc && !mon_psclk[u]) begin
      mon_sh[u] = {mon_sh[u][30:0], dn};
      mon_rises[u]++;
    end
    if (cs && !mon_pcs[u]) begin
      if ((u == 0 && fr_qa.size() == 0) || (u == 1 && fr_qb.size() == 0)) begin
        check("spi_extra_frame_rises", mon_rises[u], 0);
      end else begin
        if (u == 0) e = fr_qa.pop_front();
        else        e = fr_qb.pop_front();
        check(u == 0 ? "a_spi_frame" : "b_spi_frame", mon_sh[u], e);
        check(u == 0 ? "a_spi_rises" : "b_spi_rises", mon_rises[u], (u == 0) ? A_N : B_N);
        check(u == 0 ? "a_sclk_idle" : "b_sclk_idle", {sc, dn}, 2'b00);
      end
      mon_sh[u] = '0; mon_rises[u] = 0;
    end
    if (!ld) mon_ldac_cnt[u]++;
    if (ld && !mon_pldac[u]) begin
      check(u == 0 ? "a_ldac_low_cycles" : "b_ldac_low_cycles", mon_ldac_cnt[u], (u == 0) ? A_D : B_D);
      mon_ldac_cnt[u] = 0;
    end
    mon_psclk[u] = sc; mon_pcs[u] = cs; mon_pldac[u] = ld;
  endtask

  task automatic res_mon(input int u, input logic dv, input logic [15:0] d, input logic [3:0] c, input logic t);
    res_t e;
    if (!dv) return;
    if ((u == 0 && res_qa.size() == 0) || (u == 1 && res_qb.size() == 0)) begin
      check("extra_data_valid", dv, 1'b0);
    end else begin
      if (u == 0) e = res_qa.pop_front();
      else        e = res_qb.pop_front();
      check(u == 0 ? "a_data_out" : "b_data_out", d, e.data);
      check(u == 0 ? "a_ch_out"   : "b_ch_out",   c, e.ch);
      check(u == 0 ? "a_timeout_err" : "b_timeout_err", t, e.terr);
    end
  endtask

  always @(negedge clk) begin
    spi_mon(0, cs_a, sclk_a, din_a, ldac_a);
    spi_mon(1, cs_b, sclk_b, din_b, ldac_b);
    res_mon(0, dv_a, dout_a, 4'(chout_a), terr_a);
    res_mon(1, dv_b, dout_b, 4'(chout_b), terr_b);
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_a_busy_dv_terr"}, {busy_a, dv_a, terr_a}, 3'b000);
    check({tag, "_a_data_ch_out"},  {dout_a, chout_a}, 18'h0);
    check({tag, "_a_dac_pins"},     {cs_a, ldac_a, sclk_a, din_a}, 4'b1100);
    check({tag, "_a_adc_pins"},     {req_a, adc_ch_a}, 3'b000);
    check({tag, "_b_outputs"},
          {busy_b, dv_b, terr_b, dout_b, chout_b, cs_b, ldac_b, sclk_b, din_b, req_b, adc_ch_b},
          {3'b000, 16'h0, 3'b000, 4'b1100, 1'b0, 3'b000});
  endtask

  // Called at a negedge with the target instance idle. Returns at the negedge
  // of the first IDLE cycle after DONE, so the next call is back-to-back.
  task automatic run_txn(input int u, input vec_t v, input bit glitch, input bit done_glitch);
    int   lat, exp_lat, lim, glitch_b;
    res_t r;
    logic dv, bz;
    r.data = v.exp_out; r.ch = v.ch; r.terr = v.exp_terr;
    if (u == 0) begin
      delay_a = v.ack_delay; val_a = v.adc_val; ch_sel_a = v.ch[1:0]; data_a = v.data;
      fr_qa.push_back(v.exp_frame); res_qa.push_back(r); start_a = 1'b1;
      exp_lat = A_F - 1 + ((v.ack_delay < 0) ? A_T - 1 : v.ack_delay);
    end else begin
      delay_b = v.ack_delay; val_b = v.adc_val; ch_sel_b = v.ch[2:0]; data_b = v.data[11:0];
      fr_qb.push_back(v.exp_frame); res_qb.push_back(r); start_b = 1'b1;
      exp_lat = B_F - 1 + ((v.ack_delay < 0) ? B_T - 1 : v.ack_delay);
    end
    lim      = exp_lat + 50;
    glitch_b = 2*A_D*A_N + A_D + 10;   // inside SETTLE on instance A
    @(posedge clk);                    // accepting edge
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    lat = 0;
    dv  = 1'b0;
    while (lat < lim) begin
      @(negedge clk);
      lat++;
      dv = (u == 0) ? dv_a : dv_b;
      if (dv) break;
      start_a = (u == 0) && glitch && (lat == 20 || lat == glitch_b);
    end
    start_a = 1'b0;
    check(u == 0 ? "a_latency" : "b_latency", lat, exp_lat);
    bz = (u == 0) ? busy_a : busy_b;
    check("busy_in_done", bz, 1'b1);
    if (done_glitch) begin
      if (u == 0) start_a = 1'b1; else start_b = 1'b1;
    end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    bz = (u == 0) ? busy_a : busy_b;
    check(done_glitch ? "busy_after_done_start" : "busy_after_done", bz, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[20];
    vec_t v;
    logic [15:0] w;

    tbl[0] = '{ch:4'd2, data:16'h8001, ack_delay:3, adc_val:16'h1234,
               exp_frame:32'h0032_8001, exp_out:16'h1234, exp_terr:1'b0};
    for (int i = 0; i < 16; i++) begin
      w = 16'h0001 << i;
      tbl[i+1] = '{ch:4'(i % 4), data:w, ack_delay:i % 3, adc_val:16'hA000 | 16'(i),
                   exp_frame:{8'h00, 4'h3, 2'b00, 2'(i % 4), w},
                   exp_out:16'hA000 | 16'(i), exp_terr:1'b0};
    end
    tbl[17] = '{ch:4'd1, data:16'h5A5A, ack_delay:-1, adc_val:16'h0000,
                exp_frame:32'h0031_5A5A, exp_out:16'hFFFF, exp_terr:1'b1};
    tbl[18] = '{ch:4'd3, data:16'hFFFF, ack_delay:0, adc_val:16'h0042,
                exp_frame:32'h0033_FFFF, exp_out:16'h0042, exp_terr:1'b0};
    tbl[19] = '{ch:4'd0, data:16'h0F0F, ack_delay:1, adc_val:16'hCAFE,
                exp_frame:32'h0030_0F0F, exp_out:16'hCAFE, exp_terr:1'b0};

    rst = 1'b0;
    start_a = 1'b0; ch_sel_a = '0; data_a = '0;
    start_b = 1'b0; ch_sel_b = '0; data_b = '0;
    repeat (3) @(negedge clk);
    check_reset_state("power_up");
    rst = 1'b1;
    @(negedge clk);

    // Directed case, walking ones, timeout then recovery, start glitches.
    for (int i = 0; i < 20; i++) run_txn(0, tbl[i], i == 19, i == 0);

    // One-cycle reset mid-SHIFT: abort with no data_valid.
    ch_sel_a = 2'd3; data_a = 16'hDEAD; delay_a = 0; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_mid_shift", busy_a, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("mid_shift_rst");
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check("busy_after_abort", busy_a, 1'b0);
    v = '{ch:4'd1, data:16'h7E81, ack_delay:2, adc_val:16'h1111,
          exp_frame:32'h0031_7E81, exp_out:16'h1111, exp_terr:1'b0};
    run_txn(0, v, 1'b0, 1'b0);

    // Parameter-swept instance: 20-bit frame, 3-bit channel.
    v = '{ch:4'd7, data:16'h0ABC, ack_delay:0, adc_val:16'h0BEE,
          exp_frame:32'h0003_7ABC, exp_out:16'h0BEE, exp_terr:1'b0};
    run_txn(1, v, 1'b0, 1'b0);
    v = '{ch:4'd5, data:16'h0123, ack_delay:-1, adc_val:16'h0000,
          exp_frame:32'h0003_5123, exp_out:16'hFFFF, exp_terr:1'b1};
    run_txn(1, v, 1'b0, 1'b0);
    v = '{ch:4'd2, data:16'h0FFF, ack_delay:1, adc_val:16'h0777,
          exp_frame:32'h0003_2FFF, exp_out:16'h0777, exp_terr:1'b0};
    run_txn(1, v, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("a_queues_drained", fr_qa.size() + res_qa.size(), 0);
    check("b_queues_drained", fr_qb.size() + res_qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
